// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit.
// Contents:
//   PC_RESET_VECTOR_DEFAULT / PC_EXC_VECTOR_DEFAULT - default vectors (32-bit form)
//   pc_src_e                                        - next-PC source select
//   src_clears_pend()                               - which sources consume the pending redirect
package pc_pkg;

  localparam logic [31:0] PC_RESET_VECTOR_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] PC_EXC_VECTOR_DEFAULT   = 32'h0000_4180;

  typedef enum logic [2:0] {
    SRC_RESET = 3'd0,
    SRC_EXC   = 3'd1,
    SRC_ERET  = 3'd2,
    SRC_HOLD  = 3'd3,
    SRC_JUMP  = 3'd4,
    SRC_BR    = 3'd5,
    SRC_PEND  = 3'd6,
    SRC_SEQ   = 3'd7
  } pc_src_e;

  // A pending redirect is dropped whenever the PC is steered by anything
  // other than a hold or plain sequential fetch: exception entry/return and
  // live redirects make the buffered target stale, and SRC_PEND consumes it.
  function automatic logic src_clears_pend(input pc_src_e src);
    logic clr;
    case (src)
      SRC_EXC, SRC_ERET, SRC_JUMP, SRC_BR, SRC_PEND: clr = 1'b1;
      default:                                       clr = 1'b0;
    endcase
    return clr;
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority encoder. Holds no state.
// Ports:
//   Reset, ExcReq, Eret, Exl, Stall, Jump, BrTaken, PendValid - request/state inputs
//   JumpTarget, BrTarget, PendTarget, Pc, Epc                 - candidate PC values
//   Src    - selected next-PC source
//   NextPc - value the PC register loads on the next posedge
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR_DEFAULT),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(PC_EXC_VECTOR_DEFAULT)
) (
  input  logic             Reset,
  input  logic             ExcReq,
  input  logic             Eret,
  input  logic             Exl,
  input  logic             Stall,
  input  logic             Jump,
  input  logic [WIDTH-1:0] JumpTarget,
  input  logic             BrTaken,
  input  logic [WIDTH-1:0] BrTarget,
  input  logic             PendValid,
  input  logic [WIDTH-1:0] PendTarget,
  input  logic [WIDTH-1:0] Pc,
  input  logic [WIDTH-1:0] Epc,
  output pc_src_e          Src,
  output logic [WIDTH-1:0] NextPc
);

  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(32'd4);

  pc_src_e          src_s;
  logic [WIDTH-1:0] next_pc_s;

  // Priority chain. Exception requests while already in the handler and
  // Eret outside the handler fall through to the lower-priority checks.
  always_comb begin
    src_s     = SRC_SEQ;
    next_pc_s = Pc + PC_STEP;
    if (Reset) begin
      src_s     = SRC_RESET;
      next_pc_s = RESET_VECTOR;
    end else if (ExcReq && !Exl) begin
      src_s     = SRC_EXC;
      next_pc_s = EXC_VECTOR;
    end else if (Eret && Exl) begin
      src_s     = SRC_ERET;
      next_pc_s = Epc;
    end else if (Stall) begin
      src_s     = SRC_HOLD;
      next_pc_s = Pc;
    end else if (Jump) begin
      src_s     = SRC_JUMP;
      next_pc_s = JumpTarget;
    end else if (BrTaken) begin
      src_s     = SRC_BR;
      next_pc_s = BrTarget;
    end else if (PendValid) begin
      src_s     = SRC_PEND;
      next_pc_s = PendTarget;
    end else begin
      src_s     = SRC_SEQ;
      next_pc_s = Pc + PC_STEP;
    end
  end

  assign Src    = src_s;
  assign NextPc = next_pc_s;

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit at the head of the fetch stage.
// Ports:
//   Clk, Reset            - clock; synchronous active-high reset
//   Stall                 - hold pc this cycle (redirects get buffered)
//   BrTaken/BrTarget      - branch redirect
//   Jump/JumpTarget       - jump/jr redirect (wins over a branch)
//   ExcReq/ExcPC          - exception entry and faulting PC
//   Eret                  - return from exception
//   pc, pc_plus4          - fetch address and its sequential successor
//   Epc, Exl              - saved exception PC and exception level
//   Misaligned            - pc not word aligned
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR_DEFAULT),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(PC_EXC_VECTOR_DEFAULT)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             BrTaken,
  input  logic [WIDTH-1:0] BrTarget,
  input  logic             Jump,
  input  logic [WIDTH-1:0] JumpTarget,
  input  logic             ExcReq,
  input  logic [WIDTH-1:0] ExcPC,
  input  logic             Eret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] Epc,
  output logic             Exl,
  output logic             Misaligned
);

  localparam logic [0:0]       ST_NORMAL = 1'b0;
  localparam logic [0:0]       ST_EXC    = 1'b1;
  localparam logic [WIDTH-1:0] PC_STEP   = WIDTH'(32'd4);

  logic [WIDTH-1:0] pc_r;
  logic [WIDTH-1:0] epc_r;
  logic [0:0]       exl_r;
  logic             pend_valid_r;
  logic [WIDTH-1:0] pend_target_r;

  pc_src_e          src_s;
  logic [WIDTH-1:0] next_pc_s;

  pc_next_sel #(
    .WIDTH        (WIDTH),
    .RESET_VECTOR (RESET_VECTOR),
    .EXC_VECTOR   (EXC_VECTOR)
  ) u_next_sel (
    .Reset      (Reset),
    .ExcReq     (ExcReq),
    .Eret       (Eret),
    .Exl        (exl_r == ST_EXC),
    .Stall      (Stall),
    .Jump       (Jump),
    .JumpTarget (JumpTarget),
    .BrTaken    (BrTaken),
    .BrTarget   (BrTarget),
    .PendValid  (pend_valid_r),
    .PendTarget (pend_target_r),
    .Pc         (pc_r),
    .Epc        (epc_r),
    .Src        (src_s),
    .NextPc     (next_pc_s)
  );

  // PC register: always loads the selected next value.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_r <= RESET_VECTOR;
    end else begin
      pc_r <= next_pc_s;
    end
  end

  // Exception-level FSM and EPC capture. EPC is only written on an accepted
  // exception entry, so an ignored nested request leaves it untouched.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      exl_r <= ST_NORMAL;
      epc_r <= '0;
    end else begin
      case (src_s)
        SRC_EXC: begin
          exl_r <= ST_EXC;
          epc_r <= ExcPC;
        end
        SRC_ERET: begin
          exl_r <= ST_NORMAL;
        end
        default: begin
        end
      endcase
    end
  end

  // One-entry pending redirect buffer. While stalled the newest redirect
  // overwrites whatever is buffered; Jump takes precedence over BrTaken.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pend_valid_r  <= 1'b0;
      pend_target_r <= '0;
    end else if (src_s == SRC_HOLD) begin
      if (Jump) begin
        pend_valid_r  <= 1'b1;
        pend_target_r <= JumpTarget;
      end else if (BrTaken) begin
        pend_valid_r  <= 1'b1;
        pend_target_r <= BrTarget;
      end
    end else if (src_clears_pend(src_s)) begin
      pend_valid_r <= 1'b0;
    end
  end

  assign pc         = pc_r;
  assign pc_plus4   = pc_r + PC_STEP;
  assign Epc        = epc_r;
  assign Exl        = exl_r[0];
  assign Misaligned = |pc_r[1:0];

endmodule

// File: tb/tb_pc_unit.sv
// Directed, scoreboarded bench for pc_unit. A 32-bit instance covers the
// main behaviour; a 16-bit instance covers address wrap. Only one instance
// is out of reset at a time; sel16 picks which one a step drives and checks.
module tb_pc_unit;

  logic        Clk = 1'b0;
  logic        reset32 = 1'b1;
  logic        reset16 = 1'b1;
  logic        Stall = 1'b0;
  logic        BrTaken = 1'b0;
  logic        Jump = 1'b0;
  logic        ExcReq = 1'b0;
  logic        Eret = 1'b0;
  logic [31:0] BrTarget = 32'h0;
  logic [31:0] JumpTarget = 32'h0;
  logic [31:0] ExcPC = 32'h0;

  logic [31:0] pc32, pc_plus4_32, epc32;
  logic        exl32, mis32;
  logic [15:0] pc16, pc_plus4_16, epc16;
  logic        exl16, mis16;

  logic sel16 = 1'b0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] epc;
    logic        exl;
  } exp_t;

  exp_t sb[$];

  always #5 Clk = ~Clk;

  pc_unit #(.WIDTH(32)) dut32 (
    .Clk(Clk), .Reset(reset32), .Stall(Stall),
    .BrTaken(BrTaken), .BrTarget(BrTarget),
    .Jump(Jump), .JumpTarget(JumpTarget),
    .ExcReq(ExcReq), .ExcPC(ExcPC), .Eret(Eret),
    .pc(pc32), .pc_plus4(pc_plus4_32), .Epc(epc32), .Exl(exl32), .Misaligned(mis32)
  );

  pc_unit #(.WIDTH(16)) dut16 (
    .Clk(Clk), .Reset(reset16), .Stall(Stall),
    .BrTaken(BrTaken), .BrTarget(BrTarget[15:0]),
    .Jump(Jump), .JumpTarget(JumpTarget[15:0]),
    .ExcReq(ExcReq), .ExcPC(ExcPC[15:0]), .Eret(Eret),
    .pc(pc16), .pc_plus4(pc_plus4_16), .Epc(epc16), .Exl(exl16), .Misaligned(mis16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge state, then
  // pop it after the edge and compare against the selected instance.
  task automatic step(input string tag,
                      input logic rst, input logic st, input logic br, input logic j,
                      input logic exc, input logic er,
                      input logic [31:0] brt, input logic [31:0] jt, input logic [31:0] epc_in,
                      input logic [31:0] e_pc, input logic [31:0] e_epc, input logic e_exl);
    exp_t        e;
    logic [31:0] o_pc, o_p4, o_epc, e_p4;
    logic        o_exl, o_mis;
    reset32    = sel16 ? 1'b1 : rst;
    reset16    = sel16 ? rst : 1'b1;
    Stall      = st;
    BrTaken    = br;
    Jump       = j;
    ExcReq     = exc;
    Eret       = er;
    BrTarget   = brt;
    JumpTarget = jt;
    ExcPC      = epc_in;
    sb.push_back('{tag, e_pc, e_epc, e_exl});
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    if (sel16) begin
      o_pc  = {16'h0, pc16};
      o_p4  = {16'h0, pc_plus4_16};
      o_epc = {16'h0, epc16};
      o_exl = exl16;
      o_mis = mis16;
      e_p4  = (e.pc + 32'd4) & 32'h0000_FFFF;
    end else begin
      o_pc  = pc32;
      o_p4  = pc_plus4_32;
      o_epc = epc32;
      o_exl = exl32;
      o_mis = mis32;
      e_p4  = e.pc + 32'd4;
    end
    check({e.tag, ".pc"},         o_pc,            e.pc);
    check({e.tag, ".pc_plus4"},   o_p4,            e_p4);
    check({e.tag, ".epc"},        o_epc,           e.epc);
    check({e.tag, ".exl"},        {31'h0, o_exl},  {31'h0, e.exl});
    check({e.tag, ".misaligned"}, {31'h0, o_mis},  {31'h0, (e.pc[1:0] != 2'b00)});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    // tag            rst   st    br    j     exc   er    BrTarget      JumpTarget    ExcPC         exp pc        exp epc       exl
    // Reset and sequential fetch
    step("rst0",      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0000_3000, 32'h0,        1'b0);
    step("rst1",      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0000_3000, 32'h0,        1'b0);
    step("seq1",      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0000_3004, 32'h0,        1'b0);
    step("seq2",      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0000_3008, 32'h0,        1'b0);
    step("seq3",      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0000_300C, 32'h0,        1'b0);
    step("seq4",      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0000_3010, 32'h0,        1'b0);
    // Redirect during a 3-cycle stall
    step("stall_br",  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_3100, 32'h0,       32'h0,        32'h0000_3010, 32'h0,        1'b0);
    step("stall2",    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0000_3010, 32'h0,        1'b0);
    step("stall3",    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0000_3010, 32'h0,        1'b0);
    step("release",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0000_3100, 32'h0,        1'b0);
    step("after_rel", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0000_3104, 32'h0,        1'b0);
    // Simultaneous and overwritten redirects
    step("jmp_br",    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_3200, 32'h0000_3400, 32'h0,      32'h0000_3400, 32'h0,        1'b0);
    step("st_br",     1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_3200, 32'h0,       32'h0,        32'h0000_3400, 32'h0,        1'b0);
    step("st_jmp",    1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0000_3300, 32'h0,       32'h0000_3400, 32'h0,        1'b0);
    step("rel_ovw",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0000_3300, 32'h0,        1'b0);
    step("seq5",      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0000_3304, 32'h0,        1'b0);
    // Live redirect beats a stale pending entry and clears it
    step("st_stale",  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_3500, 32'h0,       32'h0,        32'h0000_3304, 32'h0,        1'b0);
    step("live_br",   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_3600, 32'h0,       32'h0,        32'h0000_3600, 32'h0,        1'b0);
    step("no_stale",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0000_3604, 32'h0,        1'b0);
    // Exception entry during stall, nesting, return
    step("st_pend",   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_3700, 32'h0,       32'h0,        32'h0000_3604, 32'h0,        1'b0);
    step("exc_stall", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        32'h0000_3020, 32'h0000_4180, 32'h0000_3020, 1'b1);
    step("handler",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0000_4184, 32'h0000_3020, 1'b1);
    step("nest_ign",  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        32'h0000_4184, 32'h0000_4188, 32'h0000_3020, 1'b1);
    step("eret",      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        32'h0,        32'h0000_3020, 32'h0000_3020, 1'b0);
    step("seq6",      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0000_3024, 32'h0000_3020, 1'b0);
    step("eret_ign",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        32'h0,        32'h0000_3028, 32'h0000_3020, 1'b0);
    step("exc_eret",  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        32'h0,        32'h0000_3028, 32'h0000_4180, 32'h0000_3028, 1'b1);
    step("nest_st",   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        32'h0000_5000, 32'h0000_4180, 32'h0000_3028, 1'b1);
    step("eret_st",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        32'h0,        32'h0000_3028, 32'h0000_3028, 1'b0);
    // Reset in the handler with a redirect pending
    step("exc6",      1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        32'h0000_3030, 32'h0000_4180, 32'h0000_3030, 1'b1);
    step("st_pend6",  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_3800, 32'h0,       32'h0,        32'h0000_4180, 32'h0000_3030, 1'b1);
    step("rst_mid",   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0000_3000, 32'h0,        1'b0);
    step("post_rst1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0000_3004, 32'h0,        1'b0);
    step("post_rst2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0000_3008, 32'h0,        1'b0);
    // Misaligned target and 32-bit wrap
    step("mis_jmp",   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0000_3002, 32'h0,       32'h0000_3002, 32'h0,        1'b0);
    step("mis_seq",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0000_3006, 32'h0,        1'b0);
    step("top32",     1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'hFFFF_FFFC, 32'h0,       32'hFFFF_FFFC, 32'h0,        1'b0);
    step("wrap32",    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0000_0000, 32'h0,        1'b0);

    // 16-bit instance: wrap and misalignment
    sel16 = 1'b1;
    step("w16_rst0",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0000_3000, 32'h0,        1'b0);
    step("w16_rst1",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0000_3000, 32'h0,        1'b0);
    step("w16_seq",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0000_3004, 32'h0,        1'b0);
    step("w16_top",   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0000_FFFC, 32'h0,       32'h0000_FFFC, 32'h0,        1'b0);
    step("w16_wrap",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0000_0000, 32'h0,        1'b0);
    step("w16_misj",  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0000_3002, 32'h0,       32'h0000_3002, 32'h0,        1'b0);
    step("w16_miss",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0000_3006, 32'h0,        1'b0);

    check("sb_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the MIPS datapath. It is the successor to the plain reset-and-load PC register, and sits at the head of the fetch stage, driving the instruction-memory address. It computes the next PC internally and supports:
- stall hold;
- branch/jump redirect, with a one-entry pending-redirect buffer for redirects that arrive during a stall;
- exception entry, with EPC capture and an exception-level state;
- ERET return.

## Interface
- WIDTH, 32, address width (≥ 8).
- RESET_VECTOR, 32'h0000_3000, PC value after reset.
- EXC_VECTOR, 32'h0000_4180, exception handler entry address.

Ports (one clock; reset is synchronous and active-high):
- Clk  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high; dominates every other input.
- Stall  in  1  hold PC this cycle.
- BrTaken  in  1  branch redirect request.
- BrTarget  in  WIDTH  branch target.
- Jump  in  1  jump/jr redirect request.
- JumpTarget  in  WIDTH  jump target.
- ExcReq  in  1  exception request.
- ExcPC  in  WIDTH  PC of the faulting instruction.
- Eret  in  1  return from exception.
- pc  out  WIDTH  current fetch address.
- pc_plus4  out  WIDTH  pc + 4, combinational, modulo 2^WIDTH.
- Epc  out  WIDTH  saved exception PC.
- Exl  out  1  exception level (1 = in handler).
- Misaligned  out  1  combinational: pc[1:0] != 0.

## Operation
- **Reset:** pc = RESET_VECTOR, Epc = 0, Exl = 0, pending buffer empty (PendValid = 0, PendTarget = 0).
- **Two-state FSM on Exl:**
  - NORMAL → EXC on accepted ExcReq.
  - EXC → NORMAL on accepted Eret.
- **Per-cycle next-PC priority (highest first):**
  1. Reset.
  2. ExcReq with Exl = 0: pc ← EXC_VECTOR, Epc ← ExcPC, Exl ← 1, pending cleared. Overrides Stall.
  3. Eret with Exl = 1: pc ← Epc, Exl ← 0, pending cleared. Overrides Stall.
  4. Stall = 1: pc holds. If BrTaken or Jump is asserted, capture the target into the pending buffer (Jump wins over BrTaken). A newer redirect overwrites an older pending one.
  5. Stall = 0 with Jump: pc ← JumpTarget.
  6. Stall = 0 with BrTaken: pc ← BrTarget.
  7. Stall = 0 with pending valid: pc ← PendTarget, pending cleared.
  8. Otherwise: pc ← pc + 4.
- Live redirects in steps 5–6 override a stale pending entry; the pending entry is cleared in that cycle.
- **Ignored requests:**
  - ExcReq while Exl = 1 (no nesting): ignored. Epc is unchanged and evaluation continues down the list.
  - Eret while Exl = 0: ignored.
  - ExcReq and Eret in the same cycle with Exl = 0: ExcReq is taken.
- **Arithmetic:** all additions are modulo 2^WIDTH; wrap-around is silent.
- **Targets are loaded unmodified.** A misaligned target raises Misaligned while that value is in pc. Reporting it is the core's job.

## Timing
- Every state change lands one cycle after the inputs are sampled; there is no combinational path from inputs to pc.
- pc_plus4 and Misaligned are combinational from pc.
- A redirect arriving during a stall of N cycles takes effect on the posedge of the first cycle with Stall = 0.
- The pending buffer holds one entry.
- Reset asserted mid-handler or with a redirect pending discards all state in one cycle.
- Reset must be held ≥ 1 posedge.

## Structure
- **Shared package pc_pkg:**
  - Default RESET_VECTOR and EXC_VECTOR constants.
  - Next-PC source enum: SRC_RESET, SRC_EXC, SRC_ERET, SRC_HOLD, SRC_JUMP, SRC_BR, SRC_PEND, SRC_SEQ.
- **Sub-module pc_next_sel:** purely combinational priority encoder that produces the source select and the next value. pc_unit keeps all registers: pc, Epc, Exl, PendValid, PendTarget.

## Test plan
1. **Reset and sequential fetch:** Reset for 2 cycles, then 3 free cycles → pc = 0x3000, 0x3004, 0x3008, 0x300C; Exl = 0; Epc = 0.
2. **Redirect during stall:** at pc = 0x3010, Stall = 1 for 3 cycles with BrTaken = 1, BrTarget = 0x3100 in the first stall cycle only → pc holds 0x3010, then pc = 0x3100 on the first unstalled cycle, then 0x3104.
3. **Simultaneous and overwritten redirects:** Jump (0x3400) and BrTaken (0x3200) in the same unstalled cycle → pc = 0x3400. During a stall, BrTaken 0x3200 then Jump 0x3300 → pc = 0x3300 after release.
4. **Exception entry, nesting and return:**
   - ExcReq = 1, ExcPC = 0x3020 while Stall = 1 → pc = 0x4180, Epc = 0x3020, Exl = 1, pending cleared.
   - Second ExcReq with ExcPC = 0x4184 → Epc stays 0x3020.
   - Eret → pc = 0x3020, Exl = 0.
5. **Wrap and misalignment (WIDTH = 16):**
   - pc = 0xFFFC → next pc = 0x0000.
   - Jump to 0x3002 → Misaligned = 1 for that cycle; pc = 0x3006 next, Misaligned stays 1.
6. **Reset mid-operation:** Reset with Exl = 1 and a pending redirect → next cycle pc = 0x3000, Exl = 0, Epc = 0, and the pending target never applied.
